phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/mem_wait_timer.sv | 48 ++++
 rtl/phase_sequencer.sv | 139 +++++++++++++
 tb/tb_phase_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared phase encodings, sequencer defaults and opcode constants
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_REG_READ = 4'd3;
    localparam logic [3:0] ST_EXECUTE  = 4'd4;
    localparam logic [3:0] ST_MEM      = 4'd5;
    localparam logic [3:0] ST_WB_SEL   = 4'd6;
    localparam logic [3:0] ST_WB       = 4'd7;
    localparam logic [3:0] ST_PC_UPD   = 4'd8;
    localparam logic [3:0] ST_HALTED   = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_REG_READ = ST_REG_READ,
        S_EXECUTE  = ST_EXECUTE,
        S_MEM      = ST_MEM,
        S_WB_SEL   = ST_WB_SEL,
        S_WB       = ST_WB,
        S_PC_UPD   = ST_PC_UPD,
        S_HALTED   = ST_HALTED
    } phase_e;

    localparam int         MEM_TIMEOUT_DEFAULT = 15;
    localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'b1111;

    // Opcodes decoded by control_unit
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts MEM-phase wait cycles and flags the timeout cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int             CW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Fires on the wait cycle that would be number MEM_TIMEOUT
    assign expired = count_en && !clear && (count_q == LIMIT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ============================================================================
// Module      : phase_sequencer
// Description : Multi-cycle instruction phase sequencer with MEM timeout
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int         MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic       resume,
    input  logic [3:0] opcode,
    input  logic       mem_r_en,
    input  logic       mem_w_en,
    input  logic       reg_w_en,
    input  logic       mem_ready,
    output logic       fetch,
    output logic       decode,
    output logic       reg_rd,
    output logic       execute,
    output logic       access_mem,
    output logic       wb_sel,
    output logic       wb,
    output logic       update_pc,
    output logic [3:0] state,
    output logic       busy,
    output logic       halted,
    output logic       err,
    output logic [7:0] instr_count
);

    phase_e     state_q, state_d;
    logic       err_q, err_d;
    logic       mem_first_q, mem_first_d;
    logic [7:0] instr_count_q, instr_count_d;

    logic w_timer_clear;
    logic w_timer_count_en;
    logic w_timer_expired;

    assign w_timer_clear    = (state_q != S_MEM);
    assign w_timer_count_en = (state_q == S_MEM) && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_timer_clear),
        .count_en (w_timer_count_en),
        .expired  (w_timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        mem_first_d   = 1'b0;
        instr_count_d = instr_count_q;
        case (state_q)
            S_IDLE:     if (run || step) state_d = S_FETCH;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = (opcode == HALT_OPCODE) ? S_HALTED : S_REG_READ;
            S_REG_READ: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (mem_r_en || mem_w_en) begin
                    state_d     = S_MEM;
                    mem_first_d = 1'b1;
                end else if (reg_w_en) begin
                    state_d = S_WB_SEL;
                end else begin
                    state_d = S_PC_UPD;
                end
            end
            S_MEM: begin
                // A late mem_ready still beats a timeout in the same cycle
                if (mem_ready) begin
                    state_d = reg_w_en ? S_WB_SEL : S_PC_UPD;
                end else if (w_timer_expired) begin
                    state_d = S_HALTED;
                    err_d   = 1'b1;
                end
            end
            S_WB_SEL:   state_d = S_WB;
            S_WB:       state_d = S_PC_UPD;
            S_PC_UPD: begin
                instr_count_d = instr_count_q + 8'd1;
                state_d       = run ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
                if (resume) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            err_q         <= 1'b0;
            mem_first_q   <= 1'b0;
            instr_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            mem_first_q   <= mem_first_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        fetch      = (state_q == S_FETCH);
        decode     = (state_q == S_DECODE);
        reg_rd     = (state_q == S_REG_READ);
        execute    = (state_q == S_EXECUTE);
        access_mem = (state_q == S_MEM) && mem_first_q;
        wb_sel     = (state_q == S_WB_SEL);
        wb         = (state_q == S_WB);
        update_pc  = (state_q == S_PC_UPD);
        busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
        halted     = (state_q == S_HALTED);
    end

    assign state       = state_q;
    assign err         = err_q;
    assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// Module      : tb_phase_sequencer
// Description : Scoreboard bench for phase_sequencer phase order and faults
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_sequencer;
    import cpu_pkg::*;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       run       = 1'b0;
    logic       step      = 1'b0;
    logic       resume    = 1'b0;
    logic [3:0] opcode    = OP_ADD;
    logic       mem_r_en  = 1'b0;
    logic       mem_w_en  = 1'b0;
    logic       reg_w_en  = 1'b0;
    logic       mem_ready = 1'b0;

    logic       fetch, decode, reg_rd, execute, access_mem, wb_sel, wb, update_pc;
    logic [3:0] state;
    logic       busy, halted, err;
    logic [7:0] instr_count;

    typedef struct packed {
        logic [3:0] st;
        logic       acc;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        exp_err  = 1'b0;
    logic [7:0]  exp_cnt  = 8'd0;

    always #5 clk = ~clk;

    phase_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .resume      (resume),
        .opcode      (opcode),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .reg_w_en    (reg_w_en),
        .mem_ready   (mem_ready),
        .fetch       (fetch),
        .decode      (decode),
        .reg_rd      (reg_rd),
        .execute     (execute),
        .access_mem  (access_mem),
        .wb_sel      (wb_sel),
        .wb          (wb),
        .update_pc   (update_pc),
        .state       (state),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .instr_count (instr_count)
    );

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned req);
        n_checks++;
        if (obs == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
    endtask

    // {fetch, decode, reg_rd, execute, access_mem, wb_sel, wb, update_pc}
    function automatic logic [7:0] strobes_for(input logic [3:0] st, input logic acc);
        case (st)
            ST_FETCH:    return 8'b1000_0000;
            ST_DECODE:   return 8'b0100_0000;
            ST_REG_READ: return 8'b0010_0000;
            ST_EXECUTE:  return 8'b0001_0000;
            ST_MEM:      return acc ? 8'b0000_1000 : 8'b0000_0000;
            ST_WB_SEL:   return 8'b0000_0100;
            ST_WB:       return 8'b0000_0010;
            ST_PC_UPD:   return 8'b0000_0001;
            default:     return 8'b0000_0000;
        endcase
    endfunction

    task automatic expect_st(input logic [3:0] st, input logic acc);
        exp_t e;
        e.st  = st;
        e.acc = acc;
        e.err = exp_err;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, got state 0x%0h, expected an entry", tag, state);
            return;
        end
        e = sb_q.pop_front();
        check_val({tag, " state"}, state, e.st);
        check_val({tag, " strobes"},
                  {fetch, decode, reg_rd, execute, access_mem, wb_sel, wb, update_pc},
                  strobes_for(e.st, e.acc));
        check_val({tag, " busy"}, busy, (e.st != ST_IDLE) && (e.st != ST_HALTED));
        check_val({tag, " halted"}, halted, e.st == ST_HALTED);
        check_val({tag, " err"}, err, e.err);
        check_val({tag, " count"}, instr_count, e.cnt);
    endtask

    task automatic tick(input string tag, input logic [3:0] st, input logic acc);
        expect_st(st, acc);
        @(posedge clk);
        #1;
        compare_front(tag);
        if (st == ST_PC_UPD) exp_cnt = exp_cnt + 8'd1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_st(ST_IDLE, 1'b0);
        compare_front("reset");
        rst = 1'b0;
        tick("idle", ST_IDLE, 1'b0);

        // ALU op with writeback, run dropped during PC_UPD
        opcode = OP_ADD; reg_w_en = 1'b1; run = 1'b1;
        tick("alu", ST_FETCH, 1'b0);
        tick("alu", ST_DECODE, 1'b0);
        tick("alu", ST_REG_READ, 1'b0);
        tick("alu", ST_EXECUTE, 1'b0);
        tick("alu", ST_WB_SEL, 1'b0);
        tick("alu", ST_WB, 1'b0);
        tick("alu", ST_PC_UPD, 1'b0);
        run = 1'b0;
        tick("alu_end", ST_IDLE, 1'b0);

        // Load with three wait cycles, then back-to-back halt instruction
        mem_r_en = 1'b1; reg_w_en = 1'b1; mem_ready = 1'b0; run = 1'b1;
        tick("ld", ST_FETCH, 1'b0);
        tick("ld", ST_DECODE, 1'b0);
        tick("ld", ST_REG_READ, 1'b0);
        tick("ld", ST_EXECUTE, 1'b0);
        tick("ld_mem1", ST_MEM, 1'b1);
        for (int i = 0; i < 3; i++) tick("ld_wait", ST_MEM, 1'b0);
        mem_ready = 1'b1;
        tick("ld", ST_WB_SEL, 1'b0);
        mem_ready = 1'b0; mem_r_en = 1'b0; reg_w_en = 1'b0;
        tick("ld", ST_WB, 1'b0);
        tick("ld", ST_PC_UPD, 1'b0);
        opcode = OP_HALT;
        tick("hlt", ST_FETCH, 1'b0);
        tick("hlt", ST_DECODE, 1'b0);
        tick("hlt", ST_HALTED, 1'b0);
        step = 1'b1;
        tick("hlt_step", ST_HALTED, 1'b0);
        step = 1'b0;
        tick("hlt_run", ST_HALTED, 1'b0);
        run = 1'b0; resume = 1'b1;
        tick("resume", ST_IDLE, 1'b0);
        resume = 1'b0;
        tick("resume", ST_IDLE, 1'b0);

        // Store that never completes: timeout after 15 wait cycles
        opcode = OP_SW; mem_w_en = 1'b1; mem_ready = 1'b0; step = 1'b1;
        tick("to", ST_FETCH, 1'b0);
        step = 1'b0;
        tick("to", ST_DECODE, 1'b0);
        tick("to", ST_REG_READ, 1'b0);
        tick("to", ST_EXECUTE, 1'b0);
        tick("to_mem1", ST_MEM, 1'b1);
        for (int i = 0; i < 14; i++) tick("to_wait", ST_MEM, 1'b0);
        exp_err = 1'b1;
        tick("to_fault", ST_HALTED, 1'b0);
        tick("to_hold", ST_HALTED, 1'b0);
        resume = 1'b1; exp_err = 1'b0;
        tick("to_resume", ST_IDLE, 1'b0);
        resume = 1'b0;

        // mem_ready arrives on the very cycle the timeout would fire
        step = 1'b1;
        tick("edge", ST_FETCH, 1'b0);
        step = 1'b0;
        tick("edge", ST_DECODE, 1'b0);
        tick("edge", ST_REG_READ, 1'b0);
        tick("edge", ST_EXECUTE, 1'b0);
        tick("edge_mem1", ST_MEM, 1'b1);
        for (int i = 0; i < 14; i++) tick("edge_wait", ST_MEM, 1'b0);
        mem_ready = 1'b1;
        tick("edge_exit", ST_PC_UPD, 1'b0);
        mem_ready = 1'b0; mem_w_en = 1'b0;
        tick("edge_end", ST_IDLE, 1'b0);

        // run+step together start once; step while busy is not queued
        opcode = OP_ADD; run = 1'b1; step = 1'b1;
        tick("both", ST_FETCH, 1'b0);
        run = 1'b0; step = 1'b0;
        tick("both", ST_DECODE, 1'b0);
        step = 1'b1;
        tick("busy_step", ST_REG_READ, 1'b0);
        step = 1'b0;
        tick("busy_step", ST_EXECUTE, 1'b0);
        tick("busy_step", ST_PC_UPD, 1'b0);
        tick("busy_step", ST_IDLE, 1'b0);
        tick("no_queue", ST_IDLE, 1'b0);

        // Single-step until the retired count wraps back to zero
        begin
            int n_left;
            n_left = 256 - int'(exp_cnt);
            for (int i = 0; i < n_left; i++) begin
                step = 1'b1;
                tick("wrap", ST_FETCH, 1'b0);
                step = 1'b0;
                tick("wrap", ST_DECODE, 1'b0);
                tick("wrap", ST_REG_READ, 1'b0);
                tick("wrap", ST_EXECUTE, 1'b0);
                tick("wrap", ST_PC_UPD, 1'b0);
                tick("wrap", ST_IDLE, 1'b0);
            end
        end
        check_val("wrap_zero", instr_count, 0);

        // Asynchronous reset in the middle of a MEM wait
        opcode = OP_LW; mem_r_en = 1'b1; reg_w_en = 1'b1; mem_ready = 1'b0; step = 1'b1;
        tick("arst", ST_FETCH, 1'b0);
        step = 1'b0;
        tick("arst", ST_DECODE, 1'b0);
        tick("arst", ST_REG_READ, 1'b0);
        tick("arst", ST_EXECUTE, 1'b0);
        tick("arst_mem1", ST_MEM, 1'b1);
        tick("arst_wait", ST_MEM, 1'b0);
        #2;
        rst = 1'b1;
        exp_cnt = 8'd0; exp_err = 1'b0;
        #1;
        expect_st(ST_IDLE, 1'b0);
        compare_front("arst_now");
        @(posedge clk);
        #1;
        rst = 1'b0; mem_r_en = 1'b0; reg_w_en = 1'b0;
        tick("arst_after", ST_IDLE, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
